// File: rtl/char_buf_pkg.sv
// rtl/char_buf_pkg.sv - shared types and defaults for the character buffer controller
package char_buf_pkg;

  localparam int ADDR_W        = 11;
  localparam int DEF_ROW_WORDS = 20;
  localparam int DEF_NUM_ROWS  = 60;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SCR_RD,
    SCR_WR,
    SCR_FILL,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_CLEAR   = 2'b01,
    OP_SCROLL  = 2'b10,
    OP_NOP_ALT = 2'b11
  } cmd_op_e;

endpackage

// File: rtl/char_buf_port_arb.sv
// rtl/char_buf_port_arb.sv - host/engine arbiter for the single memory port
// CHAR_BUF_CTRL_HOST_PRIO_EN: host wins every contention; otherwise round-robin.
module char_buf_port_arb (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic host_req_i,
  input  logic eng_req_i,
  input  logic eng_lock_i,
  output logic host_gnt_o,
  output logic eng_gnt_o
);

  logic host_prio_q, host_prio_d;

  // A locked engine cycle is not a contention and leaves the fairness state alone.
  assign host_gnt_o = host_req_i && !eng_lock_i && (!eng_req_i || host_prio_q);
  assign eng_gnt_o  = eng_req_i && !host_gnt_o;

`ifdef CHAR_BUF_CTRL_HOST_PRIO_EN
  assign host_prio_d = 1'b1;
`else
  logic contention;
  assign contention  = host_req_i && eng_req_i && !eng_lock_i;
  assign host_prio_d = contention ? !host_gnt_o : host_prio_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) host_prio_q <= 1'b1;
    else         host_prio_q <= host_prio_d;
  end

endmodule

// File: rtl/char_buf_scroll_ctrl.sv
// rtl/char_buf_scroll_ctrl.sv - clear/scroll engine sharing a text buffer port with a host
// Arbitration priority selected by CHAR_BUF_CTRL_HOST_PRIO_EN inside char_buf_port_arb.
module char_buf_scroll_ctrl
  import char_buf_pkg::*;
#(
  parameter int ROW_WORDS = DEF_ROW_WORDS,
  parameter int NUM_ROWS  = DEF_NUM_ROWS
) (
  input  logic              sys_clk_clk,
  input  logic              sys_reset_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_fill,
  output logic              busy,
  output logic              done,
  input  logic              host_req,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_writedata,
  input  logic [3:0]        host_byteenable,
  output logic              host_gnt,
  output logic [31:0]       host_readdata,
  output logic              host_rdvalid,
  output logic [ADDR_W-1:0] char_buffer_slave_address,
  output logic [31:0]       char_buffer_slave_writedata,
  output logic [3:0]        char_buffer_slave_byteenable,
  output logic              char_buffer_slave_chipselect,
  output logic              char_buffer_slave_write,
  output logic              char_buffer_slave_clken,
  input  logic [31:0]       char_buffer_slave_readdata
);

  localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(ROW_WORDS * NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_MOVE  = ADDR_W'(ROW_WORDS * (NUM_ROWS - 1) - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(ROW_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [7:0]        fill_q, fill_d;
  logic              live_q;
  logic              rdvalid_q;
  logic [31:0]       rdata_hold_q;

  logic              eng_req, eng_lock, eng_gnt, eng_write;
  logic [ADDR_W-1:0] eng_addr;
  logic [31:0]       eng_wdata;

  // live_q keeps cmd_ready and host grants low while reset is held.
  assign cmd_ready = (state_q == IDLE) && live_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign eng_lock  = (state_q == SCR_WR);

  char_buf_port_arb u_arb (
    .clk_i      (sys_clk_clk),
    .rst_ni     (sys_reset_reset_n),
    .host_req_i (host_req && live_q),
    .eng_req_i  (eng_req),
    .eng_lock_i (eng_lock),
    .host_gnt_o (host_gnt),
    .eng_gnt_o  (eng_gnt)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          word_d = '0;
          fill_d = cmd_fill;
          if (cmd_op == OP_CLEAR)       state_d = CLR;
          else if (cmd_op == OP_SCROLL) state_d = SCR_RD;
          else                          state_d = DONE;
        end
      end
      CLR, SCR_FILL: begin
        if (eng_gnt) begin
          if (word_q == LAST_WORD) begin
            state_d = DONE;
            word_d  = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      SCR_RD: if (eng_gnt) state_d = SCR_WR;
      SCR_WR: begin
        word_d  = word_q + 1'b1;
        state_d = (word_q == LAST_MOVE) ? SCR_FILL : SCR_RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Engine access for the current state; SCR_WR forwards last cycle's read data.
  always_comb begin
    eng_req   = 1'b0;
    eng_write = 1'b0;
    eng_addr  = word_q;
    eng_wdata = '0;
    case (state_q)
      CLR, SCR_FILL: begin
        eng_req   = 1'b1;
        eng_write = 1'b1;
        eng_wdata = {4{fill_q}};
      end
      SCR_RD: begin
        eng_req  = 1'b1;
        eng_addr = word_q + ROW_STRIDE;
      end
      SCR_WR: begin
        eng_req   = 1'b1;
        eng_write = 1'b1;
        eng_wdata = char_buffer_slave_readdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    char_buffer_slave_chipselect = 1'b0;
    char_buffer_slave_write      = 1'b0;
    char_buffer_slave_address    = '0;
    char_buffer_slave_writedata  = '0;
    char_buffer_slave_byteenable = '0;
    if (host_gnt) begin
      char_buffer_slave_chipselect = 1'b1;
      char_buffer_slave_write      = host_write;
      char_buffer_slave_address    = host_addr;
      char_buffer_slave_writedata  = host_writedata;
      char_buffer_slave_byteenable = host_byteenable;
    end else if (eng_gnt) begin
      char_buffer_slave_chipselect = 1'b1;
      char_buffer_slave_write      = eng_write;
      char_buffer_slave_address    = eng_addr;
      char_buffer_slave_writedata  = eng_wdata;
      char_buffer_slave_byteenable = 4'hF;
    end
  end

  assign char_buffer_slave_clken = 1'b1;
  assign host_rdvalid            = rdvalid_q;
  assign host_readdata           = rdvalid_q ? char_buffer_slave_readdata : rdata_hold_q;

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      fill_q       <= '0;
      live_q       <= 1'b0;
      rdvalid_q    <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      fill_q    <= fill_d;
      live_q    <= 1'b1;
      rdvalid_q <= host_gnt && !host_write;
      if (rdvalid_q) rdata_hold_q <= char_buffer_slave_readdata;
    end
  end

endmodule

// File: tb/tb_char_buf_scroll_ctrl.sv
// tb/tb_char_buf_scroll_ctrl.sv - scoreboard bench for char_buf_scroll_ctrl
// Honours CHAR_BUF_CTRL_HOST_PRIO_EN for the contention scenario.
module tb_char_buf_scroll_ctrl;

  localparam int TOTAL = 1200;
  localparam int MOVES = 1180;
`ifdef CHAR_BUF_CTRL_HOST_PRIO_EN
  localparam int HOST_WIN = 100;
  localparam int EXP_HGNT = 100;
  localparam int EXP_RUN  = 100;
`else
  localparam int HOST_WIN = 9;
  localparam int EXP_HGNT = 5;
  localparam int EXP_RUN  = 1;
`endif

  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [31:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_fill = 8'h00;
  logic        busy, done;
  logic        host_req = 1'b0, host_write = 1'b0;
  logic [10:0] host_addr = 11'h7FF;
  logic [31:0] host_writedata = 32'h0;
  logic [3:0]  host_byteenable = 4'hF;
  logic        host_gnt, host_rdvalid;
  logic [31:0] host_readdata;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = 32'h0;
  logic [3:0]  mem_be;
  logic        mem_cs, mem_we, mem_clken;

  logic [31:0] mem [0:2047];
  logic        bd_load = 1'b0;
  int          bd_mode = 0;

  acc_t        eng_q[$];
  logic [31:0] host_q[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  char_buf_scroll_ctrl dut (
    .sys_clk_clk                  (clk),
    .sys_reset_reset_n            (rst_n),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_op                       (cmd_op),
    .cmd_fill                     (cmd_fill),
    .busy                         (busy),
    .done                         (done),
    .host_req                     (host_req),
    .host_write                   (host_write),
    .host_addr                    (host_addr),
    .host_writedata               (host_writedata),
    .host_byteenable              (host_byteenable),
    .host_gnt                     (host_gnt),
    .host_readdata                (host_readdata),
    .host_rdvalid                 (host_rdvalid),
    .char_buffer_slave_address    (mem_addr),
    .char_buffer_slave_writedata  (mem_wdata),
    .char_buffer_slave_byteenable (mem_be),
    .char_buffer_slave_chipselect (mem_cs),
    .char_buffer_slave_write      (mem_we),
    .char_buffer_slave_clken      (mem_clken),
    .char_buffer_slave_readdata   (mem_rdata)
  );

  function automatic logic [31:0] pattern(input int mode, input int i);
    if (i == 2047) return 32'hCAFEF00D;
    return (mode == 0) ? 32'(i) : (32'(i) ^ 32'hA5A50000);
  endfunction

  // Byte-enabled synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bd_load) begin
      for (int i = 0; i < 2048; i++) mem[i] = pattern(bd_mode, i);
    end else if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic load_mem(input int mode);
    bd_mode = mode;
    bd_load = 1'b1;
    @(negedge clk);
    bd_load = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] fill);
    bit ok = 0;
    cmd_op = op; cmd_fill = fill; cmd_valid = 1'b1;
    for (int i = 0; i < 5000 && !ok; i++) begin
      if (cmd_ready) ok = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL cmd_accept got=timeout want=accepted"); end
  endtask

  task automatic push_clear(input logic [7:0] fill);
    for (int i = 0; i < TOTAL; i++) eng_q.push_back({1'b1, 11'(i), {4{fill}}});
  endtask

  task automatic push_scroll(input logic [7:0] fill);
    for (int d = 0; d < MOVES; d++) begin
      eng_q.push_back({1'b0, 11'(d + 20), 32'h0});
      eng_q.push_back({1'b1, 11'(d), 32'(d + 20)});
    end
    for (int i = MOVES; i < TOTAL; i++) eng_q.push_back({1'b1, 11'(i), {4{fill}}});
  endtask

  // Cycle 1 is the first cycle after the accept; host_req is held within [on, off).
  task automatic run_until_done(input int budget, input int on, input int off,
                                output int done_cyc, output int hgnt, output int max_run);
    int run = 0;
    acc_t e;
    done_cyc = -1; hgnt = 0; max_run = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      host_req = (cyc >= on) && (cyc < off);
      #1;
      checks++;
      if (host_q.size() > 0) begin
        if (host_rdvalid !== 1'b1 || host_readdata !== host_q[0]) begin
          errors++;
          $display("FAIL host_rd cyc=%0d got v=%b d=%h want v=1 d=%h", cyc, host_rdvalid, host_readdata, host_q[0]);
        end
        void'(host_q.pop_front());
      end else if (host_rdvalid !== 1'b0) begin
        errors++;
        $display("FAIL host_rdvalid cyc=%0d got=%b want=0", cyc, host_rdvalid);
      end
      if (host_gnt) begin
        hgnt++;
        if (!host_write) host_q.push_back(32'hCAFEF00D);
        if (busy) begin run++; if (run > max_run) max_run = run; end
      end else begin
        run = 0;
      end
      if (mem_cs && !host_gnt) begin
        checks++;
        if (eng_q.size() == 0) begin
          errors++;
          $display("FAIL eng_extra cyc=%0d got addr=%0d want=no access", cyc, mem_addr);
        end else begin
          e = eng_q.pop_front();
          if (mem_we !== e.we || mem_addr !== e.addr || (e.we && (mem_wdata !== e.data || mem_be !== 4'hF))) begin
            errors++;
            $display("FAIL eng_access cyc=%0d got we=%b a=%0d d=%h be=%h want we=%b a=%0d d=%h",
                     cyc, mem_we, mem_addr, mem_wdata, mem_be, e.we, e.addr, e.data);
          end
        end
      end
      if (done) done_cyc = cyc;
      @(negedge clk);
      if (done_cyc >= 0) break;
    end
    host_req = 1'b0;
    #1;
    if (host_q.size() > 0) begin
      checks++;
      if (host_rdvalid !== 1'b1 || host_readdata !== host_q[0]) begin
        errors++;
        $display("FAIL host_rd_tail got v=%b d=%h want v=1 d=%h", host_rdvalid, host_readdata, host_q[0]);
      end
      void'(host_q.pop_front());
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || eng_q.size() != 0) begin
      errors++;
      $display("FAIL post_done got done=%b busy=%b rdy=%b left=%0d want 0 0 1 0", done, busy, cmd_ready, eng_q.size());
    end
    eng_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cmd_ready, busy, done, host_gnt, host_rdvalid, mem_cs, mem_we} !== 7'b0 ||
        mem_addr !== 11'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 || host_readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals got rdy=%b busy=%b cs=%b a=%h d=%h want all zero", cmd_ready, busy, mem_cs, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || mem_clken !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b clken=%b want 1 0 1", cmd_ready, busy, mem_clken);
    end
  endtask

  task automatic test_nop;
    logic [1:0] ops [2];
    ops[0] = 2'b00; ops[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      send_cmd(ops[k], 8'h99);
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || mem_cs !== 1'b0) begin
        errors++;
        $display("FAIL nop_done op=%0d got done=%b busy=%b cs=%b want 1 1 0", ops[k], done, busy, mem_cs);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL nop_idle op=%0d got done=%b rdy=%b want 0 1", ops[k], done, cmd_ready);
      end
    end
  endtask

  task automatic test_host_access;
    logic [31:0] exp;
    load_mem(0);
    exp = (pattern(0, 11'h7F0) & 32'hFF00FF00) | (32'h11223344 & 32'h00FF00FF);
    host_req = 1'b1; host_write = 1'b1; host_addr = 11'h7F0;
    host_writedata = 32'h11223344; host_byteenable = 4'b0101;
    #1;
    checks++;
    if (host_gnt !== 1'b1 || mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'h7F0 || mem_be !== 4'b0101) begin
      errors++;
      $display("FAIL host_wr got gnt=%b cs=%b we=%b a=%h be=%b want 1 1 1 7f0 0101", host_gnt, mem_cs, mem_we, mem_addr, mem_be);
    end
    @(negedge clk);
    host_write = 1'b0; host_byteenable = 4'hF;
    #1;
    checks++;
    if (host_gnt !== 1'b1 || host_rdvalid !== 1'b0) begin
      errors++;
      $display("FAIL host_rd_gnt got gnt=%b rdv=%b want 1 0", host_gnt, host_rdvalid);
    end
    @(negedge clk);
    host_req = 1'b0; host_addr = 11'h7FF;
    #1;
    checks++;
    if (host_rdvalid !== 1'b1 || host_readdata !== exp) begin
      errors++;
      $display("FAIL host_rd_data got v=%b d=%h want v=1 d=%h", host_rdvalid, host_readdata, exp);
    end
    @(negedge clk);
    #1;
    checks++;
    if (host_rdvalid !== 1'b0 || host_readdata !== exp) begin
      errors++;
      $display("FAIL host_rd_hold got v=%b d=%h want v=0 d=%h", host_rdvalid, host_readdata, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_clear;
    int dc, hg, mr, bad;
    load_mem(0);
    push_clear(8'h20);
    send_cmd(2'b01, 8'h20);
    run_until_done(3000, -1, -1, dc, hg, mr);
    checks++;
    if (dc != 1201) begin errors++; $display("FAIL clear_done_cycle got=%0d want=1201", dc); end
    bad = 0;
    for (int i = 0; i < TOTAL; i++) if (mem[i] !== 32'h20202020) bad++;
    if (mem[1200] !== pattern(0, 1200)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_mem got bad=%0d want=0", bad); end
  endtask

  task automatic test_scroll;
    int dc, hg, mr, bad;
    load_mem(0);
    push_scroll(8'h2E);
    send_cmd(2'b10, 8'h2E);
    run_until_done(5000, -1, -1, dc, hg, mr);
    checks++;
    if (dc != 2381) begin errors++; $display("FAIL scroll_done_cycle got=%0d want=2381", dc); end
    bad = 0;
    for (int i = 0; i < MOVES; i++) if (mem[i] !== 32'(i + 20)) bad++;
    for (int i = MOVES; i < TOTAL; i++) if (mem[i] !== 32'h2E2E2E2E) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL scroll_mem got bad=%0d want=0", bad); end
  endtask

  task automatic test_scroll_host;
    int dc, hg, mr, bad;
    load_mem(0);
    push_scroll(8'h2E);
    host_write = 1'b0; host_addr = 11'h7FF;
    send_cmd(2'b10, 8'h2E);
    run_until_done(10000, 1, 1 << 30, dc, hg, mr);
    checks++;
    if (dc < 0 || hg < 100 || mr != 1) begin
      errors++;
      $display("FAIL scroll_host_arb got done=%0d grants=%0d run=%0d want done>0 grants>=100 run=1", dc, hg, mr);
    end
    bad = 0;
    for (int i = 0; i < MOVES; i++) if (mem[i] !== 32'(i + 20)) bad++;
    for (int i = MOVES; i < TOTAL; i++) if (mem[i] !== 32'h2E2E2E2E) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL scroll_host_mem got bad=%0d want=0", bad); end
  endtask

  task automatic test_cmd_held;
    int dc, hg, mr, bad, ndone = 0;
    bit acc = 0;
    load_mem(0);
    send_cmd(2'b10, 8'h2E);
    cmd_op = 2'b01; cmd_fill = 8'h41; cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 4000 && !acc; cyc++) begin
      #1;
      if (done) ndone++;
      checks++;
      if (cmd_ready) begin
        acc = 1;
        if (busy !== 1'b0) begin errors++; $display("FAIL held_ready got busy=%b want=0", busy); end
      end else if (busy !== 1'b1) begin
        errors++;
        $display("FAIL held_block cyc=%0d got rdy=0 busy=%b want busy=1", cyc, busy);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (!acc || ndone != 1 || mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'h0 || mem_wdata !== 32'h41414141) begin
      errors++;
      $display("FAIL held_start got acc=%0d dones=%0d cs=%b a=%0d d=%h want 1 1 1 0 41414141", acc, ndone, mem_cs, mem_addr, mem_wdata);
    end
    push_clear(8'h41);
    run_until_done(3000, -1, -1, dc, hg, mr);
    checks++;
    if (dc != 1201) begin errors++; $display("FAIL held_clear_done got=%0d want=1201", dc); end
    bad = 0;
    for (int i = 0; i < TOTAL; i++) if (mem[i] !== 32'h41414141) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL held_mem got bad=%0d want=0", bad); end
  endtask

  task automatic test_reset_mid;
    int nwr = 0, bad0 = 0, bad1 = 0;
    bit hit = 0;
    load_mem(1);
    send_cmd(2'b01, 8'h55);
    for (int cyc = 1; cyc <= 2000 && !hit; cyc++) begin
      #1;
      if (mem_cs && mem_we && !host_gnt) begin
        if (mem_addr == 11'd500) begin
          hit = 1;
          rst_n = 1'b0;
          #1;
          checks++;
          if ({cmd_ready, busy, done, host_gnt, host_rdvalid, mem_cs, mem_we} !== 7'b0 ||
              mem_addr !== 11'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 || host_readdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_vals got rdy=%b busy=%b cs=%b we=%b a=%0d rd=%h want all zero",
                     cmd_ready, busy, mem_cs, mem_we, mem_addr, host_readdata);
          end
        end else begin
          checks++;
          if (mem_addr !== 11'(nwr)) begin errors++; $display("FAIL midreset_seq got=%0d want=%0d", mem_addr, nwr); end
          nwr++;
        end
      end
      if (!hit) @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midreset_reach got=timeout want=word 500"); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 500; i++) if (mem[i] !== 32'h55555555) bad0++;
    for (int i = 500; i < TOTAL; i++) if (mem[i] !== pattern(1, i)) bad1++;
    checks++;
    if (bad0 != 0 || bad1 != 0) begin
      errors++;
      $display("FAIL midreset_mem got bad_lo=%0d bad_hi=%0d want 0 0", bad0, bad1);
    end
  endtask

  task automatic test_contention;
    int dc, hg, mr;
    push_clear(8'h33);
    host_write = 1'b0; host_addr = 11'h7FF;
    send_cmd(2'b01, 8'h33);
    run_until_done(3000, 50, 50 + HOST_WIN, dc, hg, mr);
    checks++;
    if (hg != EXP_HGNT || mr != EXP_RUN) begin
      errors++;
      $display("FAIL contention_grants got grants=%0d run=%0d want %0d %0d", hg, mr, EXP_HGNT, EXP_RUN);
    end
    checks++;
    if (dc != 1201 + HOST_WIN - (EXP_HGNT == HOST_WIN ? 0 : HOST_WIN - EXP_HGNT)) begin
      errors++;
      $display("FAIL contention_done got=%0d want=%0d", dc, 1201 + EXP_HGNT);
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_host_access();
    test_clear();
    test_scroll();
`ifndef CHAR_BUF_CTRL_HOST_PRIO_EN
    test_scroll_host();
`endif
    test_cmd_held();
    test_reset_mid();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
